inverter_frame_dispatch: RTL and testbench
==========================================

# inverter_frame_dispatch

Parametrised sample dispatcher between the SPI sample requester and the bank of per-module UART transmitters. It accepts one sine sample (index + id) per frame and builds a per-module word with a configurable phase offset. It serialises that word as bytes to all modules in lock-step, then issues the shoot pulse that makes every module apply its transistor state at the same instant. It replaces the hard-wired single-byte broadcast in the main FPGA top with a generic N-module, multi-byte, optionally acknowledged frame engine.

## Interface
- NUM_OF_MODULES, 9: number of UART channels driven.
- IDX_W, 12: sine index width; word width W = IDX_W+4, byte count B = ceil(W/8).
- PHASE_STEP, 0: index offset added per module; module i gets index + i*PHASE_STEP.
- SHOOT_LEN, 4: shoot pulse width in clk cycles (≥1).
- ACK_TIMEOUT, 4800: cycles to wait for module acknowledges (used only with ack feature).
- clk  in  1  system clock (24 MHz HFOSC).
- reset  in  1  asynchronous, active-low reset.
- sample_valid  in  1  sample offered.
- sample_index  in  IDX_W  sine table index.
- sample_id  in  4  uart/sequence id appended to every word.
- ready  out  1  block can accept a sample.
- start_tx  out  NUM_OF_MODULES  one-cycle start per UART.
- data_to_tx  out  8*NUM_OF_MODULES  byte per UART, module i at [8i+7:8i].
- tx_busy  in  NUM_OF_MODULES  UART transmitter busy.
- rx_done  in  NUM_OF_MODULES  UART byte received strobe.
- data_received  in  8*NUM_OF_MODULES  received byte per UART.
- shoot  out  1  synchronous fire pulse.
- frame_done  out  1  one-cycle end-of-frame strobe.
- ack_error  out  NUM_OF_MODULES  per-module error flags of last frame.

## Operation
- Handshake: sample taken when sample_valid && ready; ready=1 only in IDLE. Inputs registered at acceptance; later changes ignored.
- Word per module: idx_i = (sample_index + i*PHASE_STEP) mod 2^IDX_W; word_i = {idx_i, sample_id}, zero-padded on MSB side to 8*B bits.
- States: IDLE -> LOAD (compute words, 1 cycle) -> SEND -> GUARD -> WAIT_TX -> (next byte: SEND | last: ACK or SHOOT) -> SHOOT -> DONE -> IDLE.
- SEND: drive byte k of every word (MS byte first) on data_to_tx, pulse all start_tx bits for exactly one cycle.
- GUARD: 2 cycles, ignores tx_busy (covers UART busy-assert latency).
- WAIT_TX: hold until tx_busy == 0 on all channels.
- SHOOT: shoot=1 for SHOOT_LEN cycles, then DONE pulses frame_done for one cycle.
- Reset values: ready=0 while reset asserted, 1 in first cycle after release; start_tx=0, data_to_tx=0, shoot=0, frame_done=0, ack_error=0; state IDLE.

## Timing
- Acceptance to first start_tx: 2 cycles (LOAD, then SEND).
- Per byte: 1 (SEND) + 2 (GUARD) + UART frame time.
- Last tx_busy fall to shoot rise: 1 cycle (no ack feature).
- shoot fall to frame_done: 1 cycle; frame_done to ready: 1 cycle.
- Boundaries:
  - index wrap-around is modulo 2^IDX_W, no saturation;
  - PHASE_STEP=0 gives identical words on all channels;
  - sample_valid held high during a frame is not taken until IDLE;
  - reset mid-frame aborts at once: shoot drops, no frame_done, partial UART bytes are not recalled.

## Configuration
- DISPATCH_ACK_EN defined: after the last byte, ACK state waits for each module to echo the LS byte of its word.
  - Matching rx_done marks the module acked.
  - Mismatching byte sets ack_error[i].
  - All acked: shoot proceeds.
  - ACK_TIMEOUT expiry: unacked modules get ack_error set.
  - Any error: shoot suppressed, frame_done still pulses.
  - ack_error is cleared at next sample acceptance.
- DISPATCH_ACK_EN undefined: ACK state and rx_done/data_received logic are absent, and ack_error is tied to 0.

## Test plan
- N=3, IDX_W=12, PHASE_STEP=0x555, index 0x100, id 5 -> words 0x1005, 0x6555, 0xBAA5; bytes 0x10/0x65/0xBA then 0x05/0x55/0xA5; one shoot of 4 cycles.
- Same config, index 0xFFF -> module 1 idx 0x554, module 2 idx 0xAA9 (wrap), no overflow into id.
- tx_busy of module 2 held 100 cycles longer -> second SEND and shoot delayed until it falls; start_tx never pulses while any busy.
- sample_valid held high continuously -> exactly one acceptance per frame, ready low from accept to frame_done+1.
- Reset asserted during SHOOT -> shoot 0 immediately, no frame_done, ready 1 one cycle after release.
- DISPATCH_ACK_EN:
  - module 1 echoes 0x00 and module 2 stays silent -> ack_error=3'b110 after ACK_TIMEOUT, no shoot, frame_done pulses;
  - correct echoes -> ack_error=0 and shoot fires.

Source files
------------

// File: rtl/inverter_frame_dispatch_if.sv
// Sample-side handshake plus the per-module UART bus of the frame dispatcher.
// The dispatcher connects through master; the sample source / UART bank side uses slave.
interface inverter_frame_dispatch_if #(
    parameter int NUM_OF_MODULES = 9,
    parameter int IDX_W          = 12
);
    logic                          sample_valid;
    logic [IDX_W-1:0]              sample_index;
    logic [3:0]                    sample_id;
    logic                          ready;
    logic [NUM_OF_MODULES-1:0]     start_tx;
    logic [8*NUM_OF_MODULES-1:0]   data_to_tx;
    logic [NUM_OF_MODULES-1:0]     tx_busy;
    logic [NUM_OF_MODULES-1:0]     rx_done;
    logic [8*NUM_OF_MODULES-1:0]   data_received;
    logic                          shoot;
    logic                          frame_done;
    logic [NUM_OF_MODULES-1:0]     ack_error;

    modport master (
        input  sample_valid, sample_index, sample_id, tx_busy, rx_done, data_received,
        output ready, start_tx, data_to_tx, shoot, frame_done, ack_error
    );
    modport slave (
        output sample_valid, sample_index, sample_id, tx_busy, rx_done, data_received,
        input  ready, start_tx, data_to_tx, shoot, frame_done, ack_error
    );
endinterface

// File: rtl/inverter_frame_dispatch.sv
// N-module multi-byte frame engine: one sample in, phase-offset words out as UART bytes, then shoot.
// Optional module acknowledge stage enabled with `define DISPATCH_ACK_EN.
module inverter_frame_dispatch_lane #(
    parameter int               IDX_W  = 12,
    parameter int               WP     = 16,
    parameter logic [IDX_W-1:0] OFFSET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [IDX_W-1:0] idx,
    input  logic [3:0]       id,
    output logic [7:0]       byte_out
`ifdef DISPATCH_ACK_EN
    ,
    input  logic             clr,
    input  logic             ack_win,
    input  logic             timeout,
    input  logic             rx_done,
    input  logic [7:0]       rx_data,
    output logic             acked,
    output logic             err
`endif
);
    logic [IDX_W-1:0] idx_sum;
    logic [IDX_W+3:0] word_d;
    logic [WP-1:0]    word_q;

    // Self-determined add keeps the wrap modulo 2^IDX_W, never touching the id bits.
    assign idx_sum  = idx + OFFSET;
    assign word_d   = {idx_sum, id};
    assign byte_out = word_q[WP-1 -: 8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     word_q <= '0;
        else if (load)  word_q <= WP'(word_d);
        else if (shift) word_q <= word_q << 8;
    end

`ifdef DISPATCH_ACK_EN
    logic [7:0] lsb_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lsb_q <= '0;
            acked <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (load) lsb_q <= word_d[7:0];
            if (clr) begin
                acked <= 1'b0;
                err   <= 1'b0;
            end else if (ack_win && !acked && !err) begin
                if (rx_done) begin
                    if (rx_data == lsb_q) acked <= 1'b1;
                    else                  err   <= 1'b1;
                end else if (timeout) begin
                    err <= 1'b1;
                end
            end
        end
    end
`endif
endmodule

module inverter_frame_dispatch #(
    parameter int NUM_OF_MODULES = 9,
    parameter int IDX_W          = 12,
    parameter int PHASE_STEP     = 0,
    parameter int SHOOT_LEN      = 4,
    parameter int ACK_TIMEOUT    = 4800
) (
    input logic                    clk,
    input logic                    reset,
    inverter_frame_dispatch_if.master bus
);
    localparam int N  = NUM_OF_MODULES;
    localparam int B  = (IDX_W + 4 + 7) / 8;
    localparam int WP = 8 * B;
    localparam int CW = $clog2(ACK_TIMEOUT + SHOOT_LEN + 4);
    localparam int BW = $clog2(B + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_GUARD, S_WAIT_TX,
`ifdef DISPATCH_ACK_EN
        S_ACK,
`endif
        S_SHOOT, S_DONE
    } state_t;

    state_t                 state, state_n;
    logic                   ready_q;
    logic [IDX_W-1:0]       idx_q;
    logic [3:0]             id_q;
    logic [BW-1:0]          byte_cnt;
    logic [CW-1:0]          cnt;
    logic                   accept, send;
    logic [N-1:0][7:0]      lane_byte;

    assign accept = bus.sample_valid && ready_q;
    assign send   = (state == S_SEND);

`ifdef DISPATCH_ACK_EN
    logic [N-1:0] lane_acked, lane_err;
    logic         timeout;
    assign timeout       = (state == S_ACK) && (cnt == CW'(ACK_TIMEOUT - 1));
    assign bus.ack_error = lane_err;
`else
    logic unused_rx;
    assign unused_rx     = ^{bus.rx_done, bus.data_received};
    assign bus.ack_error = '0;
`endif

    // Registered ready so it reads 0 throughout reset and rises one edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ready_q  <= 1'b0;
            idx_q    <= '0;
            id_q     <= '0;
            byte_cnt <= '0;
            cnt      <= '0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n == S_IDLE);
            cnt     <= (state_n != state) ? '0 : cnt + 1'b1;
            if (accept) begin
                idx_q <= bus.sample_index;
                id_q  <= bus.sample_id;
            end
            if (state == S_LOAD)                                 byte_cnt <= '0;
            else if (state == S_WAIT_TX && state_n == S_SEND)    byte_cnt <= byte_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (accept) state_n = S_LOAD;
            S_LOAD:    state_n = S_SEND;
            S_SEND:    state_n = S_GUARD;
            S_GUARD:   if (cnt == CW'(1)) state_n = S_WAIT_TX;
            S_WAIT_TX: begin
                if (~|bus.tx_busy) begin
                    if (byte_cnt == BW'(B - 1))
`ifdef DISPATCH_ACK_EN
                        state_n = S_ACK;
`else
                        state_n = S_SHOOT;
`endif
                    else
                        state_n = S_SEND;
                end
            end
`ifdef DISPATCH_ACK_EN
            S_ACK: begin
                if (&(lane_acked | lane_err)) state_n = (|lane_err) ? S_DONE : S_SHOOT;
                else if (timeout)             state_n = S_DONE;
            end
`endif
            S_SHOOT:   if (cnt == CW'(SHOOT_LEN - 1)) state_n = S_DONE;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    assign bus.ready      = ready_q;
    assign bus.start_tx   = {N{send}};
    assign bus.shoot      = (state == S_SHOOT);
    assign bus.frame_done = (state == S_DONE);

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam logic [IDX_W-1:0] OFF = IDX_W'(i * PHASE_STEP);

        inverter_frame_dispatch_lane #(.IDX_W(IDX_W), .WP(WP), .OFFSET(OFF)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .load     (state == S_LOAD),
            .shift    (send),
            .idx      (idx_q),
            .id       (id_q),
            .byte_out (lane_byte[i])
`ifdef DISPATCH_ACK_EN
            ,
            .clr      (accept),
            .ack_win  (state == S_ACK),
            .timeout  (timeout),
            .rx_done  (bus.rx_done[i]),
            .rx_data  (bus.data_received[8*i +: 8]),
            .acked    (lane_acked[i]),
            .err      (lane_err[i])
`endif
        );

        assign bus.data_to_tx[8*i +: 8] = send ? lane_byte[i] : 8'h00;
    end
endmodule

// File: tb/tb_inverter_frame_dispatch.sv
// Directed bench for inverter_frame_dispatch: N=3, 12-bit index, phase step 0x555, with a UART busy model.
module tb_inverter_frame_dispatch;
    localparam int N     = 3;
    localparam int IDX_W = 12;
    localparam int PS    = 'h555;
    localparam int SL    = 4;
    localparam int AT    = 40;
    localparam int FRAME = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    inverter_frame_dispatch_if #(.NUM_OF_MODULES(N), .IDX_W(IDX_W)) bus ();

    inverter_frame_dispatch #(
        .NUM_OF_MODULES(N), .IDX_W(IDX_W), .PHASE_STEP(PS), .SHOOT_LEN(SL), .ACK_TIMEOUT(AT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // UART model and frame monitor state
    int         cyc = 0;
    int         busy_cnt [N] = '{default: 0};
    int         extra2 = 0;
    int         echo_mode [N] = '{default: 0};
    logic [7:0] cap [4][N];
    int         cap_n = 0, start_cyc [4] = '{default: 0};
    int         acc_cyc = 0, acc_cnt = 0, viol = 0;
    int         shoot_n = 0, shoot_rises = 0, shoot_first = 0, shoot_last = 0;
    int         fall_cyc = 0, fd_cnt = 0, fd_cyc = 0;
    logic       rdy_prev = 1'b0, shoot_prev = 1'b0, busy_prev = 1'b0, echo_due = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bus.rx_done       = '0;
        bus.data_received = '0;
`ifdef DISPATCH_ACK_EN
        if (echo_due) begin
            for (int i = 0; i < N; i++) begin
                if (echo_mode[i] != 2) begin
                    bus.rx_done[i] = 1'b1;
                    bus.data_received[8*i +: 8] = (echo_mode[i] == 0) ? cap[1][i] : 8'h00;
                end
            end
        end
`endif
        echo_due = 1'b0;
        if (rdy_prev && !bus.ready) begin
            acc_cnt++;
            acc_cyc = cyc;
            cap_n   = 0;
            shoot_n = 0;
        end
        rdy_prev = bus.ready;
        if (|bus.start_tx) begin
            if (|bus.tx_busy) viol++;
            if (cap_n < 4) begin
                start_cyc[cap_n] = cyc;
                for (int i = 0; i < N; i++) cap[cap_n][i] = bus.data_to_tx[8*i +: 8];
            end
            cap_n++;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.start_tx[i])     busy_cnt[i] = FRAME + ((i == 2) ? extra2 : 0);
            else if (busy_cnt[i] > 0) busy_cnt[i]--;
            bus.tx_busy[i] = (busy_cnt[i] != 0);
        end
        if (busy_prev && !(|bus.tx_busy)) begin
            fall_cyc = cyc;
            if (cap_n == 2) echo_due = 1'b1;
        end
        busy_prev = |bus.tx_busy;
        if (bus.shoot) begin
            shoot_n++;
            if (!shoot_prev) begin shoot_rises++; shoot_first = cyc; end
            shoot_last = cyc;
        end
        shoot_prev = bus.shoot;
        if (bus.frame_done) begin fd_cnt++; fd_cyc = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [11:0] idx, input logic [3:0] id);
        bus.sample_valid = 1'b1;
        bus.sample_index = idx;
        bus.sample_id    = id;
        tick();
        bus.sample_valid = 1'b0;
        chk("accept_ready_low", bus.ready, 1'b0);
    endtask

    task automatic wait_fd(input string tag, input int lim);
        int k = 0;
        while (!bus.frame_done && k < lim) begin tick(); k++; end
        chk({tag, "_frame_done"}, bus.frame_done, 1'b1);
    endtask

    int acc0, fd0, rises0;

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_index = '0;
        bus.sample_id    = '0;
        repeat (3) tick();
        chk("rst_ready",      bus.ready, 1'b0);
        chk("rst_start_tx",   bus.start_tx, 3'b000);
        chk("rst_data",       bus.data_to_tx, 24'h0);
        chk("rst_shoot",      bus.shoot, 1'b0);
        chk("rst_frame_done", bus.frame_done, 1'b0);
        chk("rst_ack_error",  bus.ack_error, 3'b000);
        reset = 1'b1;
        tick();
        chk("rel_ready", bus.ready, 1'b1);

        // Frame A: index 0x100, id 5
        send_frame(12'h100, 4'h5);
        wait_fd("A", 400);
        chk("A_bytes",  cap_n, 2);
        chk("A_b0_m0",  cap[0][0], 8'h10);
        chk("A_b0_m1",  cap[0][1], 8'h65);
        chk("A_b0_m2",  cap[0][2], 8'hBA);
        chk("A_b1_m0",  cap[1][0], 8'h05);
        chk("A_b1_m1",  cap[1][1], 8'h55);
        chk("A_b1_m2",  cap[1][2], 8'hA5);
        chk("A_first_start", start_cyc[0] - acc_cyc, 1);
        chk("A_byte_gap",    start_cyc[1] - start_cyc[0], 11);
        chk("A_shoot_len",   shoot_n, SL);
`ifndef DISPATCH_ACK_EN
        chk("A_fall_to_shoot", shoot_first - fall_cyc, 1);
`endif
        chk("A_shoot_to_done", fd_cyc - shoot_last, 1);
        chk("A_ready_at_done", bus.ready, 1'b0);
        chk("A_ack_error", bus.ack_error, 3'b000);
        tick();
        chk("A_ready_after", bus.ready, 1'b1);

        // Frame B: index wrap
        send_frame(12'hFFF, 4'h5);
        wait_fd("B", 400);
        chk("B_b0_m0", cap[0][0], 8'hFF);
        chk("B_b0_m1", cap[0][1], 8'h55);
        chk("B_b0_m2", cap[0][2], 8'hAA);
        chk("B_b1_m0", cap[1][0], 8'hF5);
        chk("B_b1_m1", cap[1][1], 8'h45);
        chk("B_b1_m2", cap[1][2], 8'h95);
        chk("B_shoot_len", shoot_n, SL);
        tick();

        // Frame C: module 2 busy 100 cycles longer
        extra2 = 100;
        send_frame(12'h100, 4'hA);
        wait_fd("C", 600);
        extra2 = 0;
        chk("C_byte_gap", start_cyc[1] - start_cyc[0], 111);
        chk("C_no_start_while_busy", viol, 0);
        chk("C_b1_m2", cap[1][2], 8'hAA);
`ifndef DISPATCH_ACK_EN
        chk("C_fall_to_shoot", shoot_first - fall_cyc, 1);
`endif
        chk("C_shoot_len", shoot_n, SL);
        tick();

        // Frame D: sample_valid held high across two frames
        acc0 = acc_cnt;
        bus.sample_valid = 1'b1;
        bus.sample_index = 12'h123;
        bus.sample_id    = 4'h3;
        tick();
        chk("D_ready_low", bus.ready, 1'b0);
        wait_fd("D1", 400);
        chk("D1_ready_at_done", bus.ready, 1'b0);
        chk("D1_b0_m2", cap[0][2], 8'hBC);
        tick();
        chk("D1_ready_after", bus.ready, 1'b1);
        tick();
        wait_fd("D2", 400);
        bus.sample_valid = 1'b0;
        chk("D_accepts", acc_cnt - acc0, 2);
        repeat (3) tick();
        chk("D_idle_ready", bus.ready, 1'b1);
        chk("D_no_extra_accept", acc_cnt - acc0, 2);

        // Frame E: reset during SHOOT
        send_frame(12'h200, 4'h1);
        begin
            int k = 0;
            while (!bus.shoot && k < 400) begin tick(); k++; end
        end
        chk("E_in_shoot", bus.shoot, 1'b1);
        fd0 = fd_cnt;
        reset = 1'b0;
        #1;
        chk("E_shoot_drop", bus.shoot, 1'b0);
        chk("E_start_tx", bus.start_tx, 3'b000);
        tick();
        chk("E_ready_in_rst", bus.ready, 1'b0);
        reset = 1'b1;
        tick();
        chk("E_ready_after", bus.ready, 1'b1);
        repeat (5) tick();
        chk("E_no_frame_done", fd_cnt - fd0, 0);

`ifdef DISPATCH_ACK_EN
        // Frame F: module 1 wrong echo, module 2 silent
        echo_mode[1] = 1;
        echo_mode[2] = 2;
        rises0 = shoot_rises;
        send_frame(12'h100, 4'h5);
        wait_fd("F", 600);
        chk("F_ack_error", bus.ack_error, 3'b110);
        chk("F_no_shoot", shoot_rises - rises0, 0);
        tick();
        echo_mode[1] = 0;
        echo_mode[2] = 0;
        send_frame(12'h100, 4'h5);
        chk("G_err_cleared", bus.ack_error, 3'b000);
        wait_fd("G", 600);
        chk("G_shoot_len", shoot_n, SL);
        chk("G_ack_error", bus.ack_error, 3'b000);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
